// File: rtl/wbucharsix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wbucharsix: ASCII to six-bit word decoder with two-entry skid buffer.    |
// | Optional: WBUCHARSIX_ERRCOUNT_EN enables the rejected-character counter. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wbucharsix (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_stb,
    input  logic [7:0] i_char,
    output logic       o_busy,
    output logic       o_stb,
    output logic [6:0] o_bits,
    input  logic       i_busy,
    output logic       o_err,
    output logic [7:0] o_err_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [6:0] r_skid;
    logic [6:0] w_skid_nx;
    logic [6:0] w_bits_nx;
    logic       w_stb_nx;
    logic       w_busy_nx;

    logic [6:0] w_word;
    logic       w_valid;
    logic       w_cr;
    logic       w_accept;
    logic       w_load;
    logic       w_reject;
    logic       w_xfer;

    // Only the low six bits of each subtraction matter, so the offsets are
    // taken modulo 64 on i_char[5:0].
    always_comb begin
        w_word  = 7'h00;
        w_valid = 1'b1;
        w_cr    = 1'b0;
        if (i_char >= 8'h30 && i_char <= 8'h39)
            w_word = {1'b0, i_char[5:0] - 6'h30};
        else if (i_char >= 8'h41 && i_char <= 8'h5a)
            w_word = {1'b0, i_char[5:0] - 6'h37};
        else if (i_char >= 8'h61 && i_char <= 8'h7a)
            w_word = {1'b0, i_char[5:0] - 6'h3d};
        else if (i_char == 8'h40)
            w_word = 7'd62;
        else if (i_char == 8'h25)
            w_word = 7'd63;
        else if (i_char == 8'h0a)
            w_word = 7'h40;
        else if (i_char == 8'h0d) begin
            w_valid = 1'b0;
            w_cr    = 1'b1;
        end else
            w_valid = 1'b0;
    end

    assign w_accept = i_stb && !o_busy;
    assign w_load   = w_accept && w_valid;
    assign w_reject = w_accept && !w_valid && !w_cr;
    assign w_xfer   = o_stb && !i_busy;

    always_comb begin
        w_state_nx = r_state;
        w_bits_nx  = o_bits;
        w_skid_nx  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_load) begin
                    w_bits_nx  = w_word;
                    w_state_nx = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_load && w_xfer)
                    w_bits_nx = w_word;
                else if (w_load) begin
                    w_skid_nx  = w_word;
                    w_state_nx = ST_FULL;
                end else if (w_xfer)
                    w_state_nx = ST_EMPTY;
            end
            ST_FULL: begin
                if (w_xfer) begin
                    w_bits_nx  = r_skid;
                    w_state_nx = ST_ONE;
                end
            end
            default: w_state_nx = ST_EMPTY;
        endcase
        // Flags are registered copies of the next state so that busy and
        // strobe come straight from flops.
        w_stb_nx  = (w_state_nx != ST_EMPTY);
        w_busy_nx = (w_state_nx == ST_FULL);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_EMPTY;
            r_skid  <= 7'h00;
            o_bits  <= 7'h00;
            o_stb   <= 1'b0;
            o_busy  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_skid  <= w_skid_nx;
            o_bits  <= w_bits_nx;
            o_stb   <= w_stb_nx;
            o_busy  <= w_busy_nx;
            o_err   <= w_reject;
        end
    end

`ifdef WBUCHARSIX_ERRCOUNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_err_count <= 8'h00;
        else if (w_reject && r_err_count != 8'hff)
            r_err_count <= r_err_count + 8'd1;
    end

    assign o_err_count = r_err_count;
`else
    assign o_err_count = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wbucharsix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wbucharsix: directed scoreboard bench for the wbucharsix decoder.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wbucharsix;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_stb;
    logic [7:0] i_char;
    logic       o_busy;
    logic       o_stb;
    logic [6:0] o_bits;
    logic       i_busy;
    logic       o_err;
    logic [7:0] o_err_count;

    int         n_vec  = 0;
    int         n_fail = 0;
    int         err_seen = 0;
    int         stb_seen = 0;
    logic [6:0] exp_q[$];

    wbucharsix dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_stb       (i_stb),
        .i_char      (i_char),
        .o_busy      (o_busy),
        .o_stb       (o_stb),
        .o_bits      (o_bits),
        .i_busy      (i_busy),
        .o_err       (o_err),
        .o_err_count (o_err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a word is consumed on every edge where o_stb=1 and i_busy=0.
    always @(negedge clk) begin
        if (o_err) err_seen++;
        if (o_stb) stb_seen++;
        if (!i_reset && o_stb && !i_busy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none", o_bits);
            end else begin
                chk("word", {25'd0, o_bits}, {25'd0, exp_q.pop_front()});
            end
        end
    end

    // Holds the character on the bus until it is accepted.
    task automatic send(input logic [7:0] c);
        int g;
        g = 0;
        i_stb  = 1'b1;
        i_char = c;
        while (o_busy && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        i_stb = 1'b0;
    endtask

    task automatic send_exp(input logic [7:0] c, input logic [6:0] w);
        exp_q.push_back(w);
        send(c);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    logic [7:0] sweep_c[8] = '{8'h30, 8'h39, 8'h41, 8'h61, 8'h7a, 8'h40, 8'h25, 8'h0a};
    logic [6:0] sweep_w[8] = '{7'd0, 7'd9, 7'd10, 7'd36, 7'd61, 7'd62, 7'd63, 7'h40};
    int e0, s0;
    logic [7:0] exp_cnt2, exp_cnt_sat;

    initial begin
`ifdef WBUCHARSIX_ERRCOUNT_EN
        exp_cnt2    = 8'd2;
        exp_cnt_sat = 8'hff;
`else
        exp_cnt2    = 8'd0;
        exp_cnt_sat = 8'd0;
`endif
        i_reset = 1'b1;
        i_stb   = 1'b0;
        i_char  = 8'h00;
        i_busy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stb",  {31'd0, o_stb},  32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_err",  {31'd0, o_err},  32'd0);
        chk("rst_bits", {25'd0, o_bits}, 32'd0);
        chk("rst_cnt",  {24'd0, o_err_count}, 32'd0);
        i_reset = 1'b0;

        // Single character, latency one, strobe for one cycle.
        send_exp("Z", 7'd35);
        chk("z_stb",  {31'd0, o_stb},  32'd1);
        chk("z_bits", {25'd0, o_bits}, 32'd35);
        @(posedge clk); #1;
        chk("z_stb_drop", {31'd0, o_stb}, 32'd0);

        for (int i = 0; i < 8; i++) send_exp(sweep_c[i], sweep_w[i]);
        drain();

        // Backpressure: third character must wait upstream.
        i_busy = 1'b1;
        send_exp("1", 7'd1);
        send_exp("2", 7'd2);
        chk("bp_busy", {31'd0, o_busy}, 32'd1);
        exp_q.push_back(7'd3);
        fork
            send("3");
            begin
                repeat (3) begin @(posedge clk); #1; end
                chk("bp_busy_hold", {31'd0, o_busy}, 32'd1);
                chk("bp_bits_hold", {25'd0, o_bits}, 32'd1);
                i_busy = 1'b0;
            end
        join
        drain();

        // Rejection: two errors, CR silent, no words.
        e0 = err_seen;
        s0 = stb_seen;
        send("#");
        send(8'h0d);
        send(8'h80);
        @(posedge clk); #1;
        chk("rej_err_pulses", err_seen - e0, 32'd2);
        chk("rej_no_stb", stb_seen - s0, 32'd0);
        chk("rej_cnt", {24'd0, o_err_count}, {24'd0, exp_cnt2});

        e0 = err_seen;
        for (int i = 0; i < 300; i++) send("!");
        @(posedge clk); #1;
        chk("sat_err_pulses", err_seen - e0, 32'd300);
        chk("sat_cnt", {24'd0, o_err_count}, {24'd0, exp_cnt_sat});

        // Reset while FULL drops both buffered words.
        i_busy = 1'b1;
        send("7");
        send("8");
        chk("full_busy", {31'd0, o_busy}, 32'd1);
        i_reset = 1'b1;
        @(posedge clk); #1;
        chk("rf_stb",  {31'd0, o_stb},  32'd0);
        chk("rf_busy", {31'd0, o_busy}, 32'd0);
        chk("rf_cnt",  {24'd0, o_err_count}, 32'd0);
        i_reset = 1'b0;
        i_busy  = 1'b0;
        send_exp("5", 7'd5);
        chk("rf_new_stb",  {31'd0, o_stb},  32'd1);
        chk("rf_new_bits", {25'd0, o_bits}, 32'd5);
        drain();

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wbucharsix.md
WBUCHARSIX -- requirements
Module: wbucharsix

Interface
REQ-001 SHALL have parameter none; the mapping is fixed; all widths below are constant.
REQ-002 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_stb  input  1  upstream character valid.
REQ-005 SHALL have port i_char  input  8  upstream ASCII character.
REQ-006 SHALL have port o_busy  output  1  upstream stall; character not accepted while high.
REQ-007 SHALL have port o_stb  output  1  decoded word valid.
REQ-008 SHALL have port o_bits  output  7  decoded word: bit6 newline flag, bits5:0 six-bit value.
REQ-009 SHALL have port i_busy  input  1  downstream stall.
REQ-010 SHALL have port o_err  output  1  one-cycle pulse per rejected character.
REQ-011 SHALL have port o_err_count  output  8  saturating count of rejected characters.

Function
REQ-012 SHALL accept a character on any cycle with i_stb=1 and o_busy=0; otherwise the character SHALL NOT be consumed.
REQ-013 SHALL decode: '0'-'9' -> 0-9; 'A'-'Z' -> 10-35; 'a'-'z' -> 36-61; '@' -> 62; '%' -> 63, with bit6=0.
REQ-014 SHALL decode 8'h0a to o_bits=7'h40.
REQ-015 SHALL silently discard 8'h0d: no output word, no o_err, no count change.
REQ-016 SHALL discard every other byte, including bytes with bit7 set, and pulse o_err for exactly the next cycle.
REQ-017 SHALL hold valid words in two registers: the output register (o_stb/o_bits) and one skid register.
REQ-018 SHALL use buffer states EMPTY (neither register valid), ONE (output register only) and FULL (both registers valid).
REQ-019 SHALL drive o_busy=1 exactly in FULL; o_busy SHALL be a registered signal.
REQ-020 SHALL present an accepted valid character on o_stb/o_bits in the following cycle when the buffer state was EMPTY (latency 1).
REQ-021 SHALL treat o_stb=1 with i_busy=0 as a transfer; o_bits SHALL hold stable while o_stb=1 and i_busy=1.
REQ-022 In ONE, SHALL load an accepted valid word into the output register when a transfer happens in the same cycle, leaving o_stb=1 and the state ONE.
REQ-023 In ONE, SHALL load an accepted valid word into the skid register when no transfer happens, moving the state to FULL.
REQ-024 In FULL, on a transfer SHALL move the skid word into the output register and go to ONE; no input is accepted that cycle.
REQ-025 In ONE, on a transfer with no valid accept SHALL clear o_stb and go to EMPTY.
REQ-026 SHALL preserve character order; no word is duplicated or lost.
REQ-027 SHALL consume an accepted invalid character or CR without changing buffer state.
REQ-028 SHALL increment o_err_count by 1 per rejected character and SHALL hold it at 8'hff once it reaches 8'hff.

Reset
REQ-029 While i_reset=1 at a clock edge, SHALL set o_stb=0, o_bits=7'h00, state EMPTY with the skid register invalid, o_busy=0, o_err=0 and o_err_count=0.
REQ-030 SHALL drop all buffered words and any in-flight o_err pulse when reset is applied in mid-operation, and SHALL accept input on the first cycle after reset is released.
REQ-031 SHALL have initial values that equal the reset values.

Configuration
REQ-032 With macro WBUCHARSIX_ERRCOUNT_EN defined, SHALL implement the o_err_count counter as specified in REQ-028.
REQ-033 Without WBUCHARSIX_ERRCOUNT_EN, SHALL tie o_err_count to constant 8'h00, with no counter logic; o_err SHALL still pulse.

Verification
REQ-034 SHALL test a single character: i_char="Z", i_busy=0 -> next cycle o_stb=1 and o_bits=7'd35 for one cycle.
REQ-035 SHALL test a full sweep: "0","9","A","a","z","@","%",8'h0a -> o_bits 0,9,10,36,61,62,63,7'h40 in order.
REQ-036 SHALL test backpressure: i_busy=1, stream "1","2","3" -> o_busy high after "2"; "3" is held upstream; after release, output is 1,2,3 with no loss.
REQ-037 SHALL test rejection: "#", 8'h0d, 8'h80 -> two o_err pulses and no o_stb; o_err_count=2 (0 without the macro).
REQ-038 SHALL test saturation: 300 invalid characters -> o_err_count=8'hff.
REQ-039 SHALL test reset in FULL: assert i_reset -> next cycle o_stb=0, o_busy=0, o_err_count=0; a new "5" yields o_bits=5.
